// File: rtl/dct_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dct_pkg : shared sizes and bank state encoding for the DCT transpose     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dct_pkg;

   localparam int DCT_N = 8;
   localparam int DCT_W = 12;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   function automatic logic is_writable(input bank_state_t s);
      return (s == EMPTY) || (s == FILLING);
   endfunction

endpackage
`default_nettype wire

// File: rtl/transpose_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | transpose_bank : N x N word store, row-major write, (row,col) async read |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module transpose_bank
   import dct_pkg::*;
#(
   parameter int W = DCT_W,
   parameter int N = DCT_N,
   localparam int LW = $clog2(N)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [LW-1:0] wr_row,
   input  logic [LW-1:0] wr_col,
   input  logic [W-1:0]  wr_data,
   input  logic [LW-1:0] rd_row,
   input  logic [LW-1:0] rd_col,
   output logic [W-1:0]  rd_data
);

   // Contents carry no reset: validity is tracked by the controller's bank state.
   logic [W-1:0] mem_q [N][N];
   logic [W-1:0] mem_d [N][N];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_row][wr_col] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_row][rd_col];

endmodule
`default_nettype wire

// File: rtl/dct_transpose_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dct_transpose_ctrl : ping-pong transpose buffer and flow control between |
// | the row and column 1-D DCT stages.          Revision: 1.0                |
// +--------------------------------------------------------------------------+
module dct_transpose_ctrl
   import dct_pkg::*;
#(
   parameter int W = DCT_W,
   parameter int N = DCT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   output logic         up_ready,
   input  logic         dn_rdy,
   input  logic         dn_hold,
   output logic         dn_ena,
   output logic [W-1:0] dn_data,
   output logic         blk_done,
   output logic         ovf_err
);

   // N must be a power of two so the counters wrap exactly at the block end.
   localparam int LW = $clog2(N);
   localparam int CW = 2 * LW;

   bank_state_t   st_q [2];
   bank_state_t   st_d [2];
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic          burst_q, burst_d;
   logic          ovf_q, ovf_d;
   logic          alive_q, alive_d;

   logic          up_ready_w;
   logic          wr_fire;
   logic          wr_last;
   logic          rd_start;
   logic          rd_act;
   logic          rd_adv;
   logic          rd_col_end;
   logic          rd_last;
   logic [W-1:0]  bank_rd_data [2];

   // Handshake and burst decode
   always_comb begin
      up_ready_w = alive_q && is_writable(st_q[wr_bank_q]);
      wr_fire    = up_valid && up_ready_w;
      wr_last    = wr_fire && (wr_cnt_q == {CW{1'b1}});
      rd_start   = !burst_q && dn_rdy && !dn_hold &&
                   ((st_q[rd_bank_q] == FULL) || (st_q[rd_bank_q] == DRAINING));
      rd_act     = rd_start || burst_q;
      rd_adv     = rd_act && !dn_hold;
      rd_col_end = (rd_cnt_q[LW-1:0] == {LW{1'b1}});
      rd_last    = rd_adv && (rd_cnt_q == {CW{1'b1}});
   end

   // Next-state for counters and the two bank state machines
   always_comb begin
      st_d[0]   = st_q[0];
      st_d[1]   = st_q[1];
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      burst_d   = burst_q;
      ovf_d     = ovf_q || (up_valid && !up_ready_w);
      alive_d   = 1'b1;

      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + CW'(1);
         if (wr_last) begin
            st_d[wr_bank_q] = FULL;
            wr_bank_d       = ~wr_bank_q;
         end else begin
            st_d[wr_bank_q] = FILLING;
         end
      end

      // The write bank is always EMPTY/FILLING and the read bank FULL/DRAINING,
      // so these updates never target the same entry.
      if (rd_start) begin
         st_d[rd_bank_q] = DRAINING;
      end

      if (rd_adv) begin
         rd_cnt_d = rd_cnt_q + CW'(1);
         burst_d  = !rd_col_end;
         if (rd_last) begin
            st_d[rd_bank_q] = EMPTY;
            rd_bank_d       = ~rd_bank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q[0]   <= EMPTY;
         st_q[1]   <= EMPTY;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         burst_q   <= 1'b0;
         ovf_q     <= 1'b0;
         alive_q   <= 1'b0;
      end else begin
         st_q[0]   <= st_d[0];
         st_q[1]   <= st_d[1];
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         burst_q   <= burst_d;
         ovf_q     <= ovf_d;
         alive_q   <= alive_d;
      end
   end

   // Read address is column-major: col in the upper bits, row in the lower.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      transpose_bank #(
         .W (W),
         .N (N)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_fire && (wr_bank_q == 1'(b))),
         .wr_row  (wr_cnt_q[CW-1:LW]),
         .wr_col  (wr_cnt_q[LW-1:0]),
         .wr_data (up_data),
         .rd_row  (rd_cnt_q[LW-1:0]),
         .rd_col  (rd_cnt_q[CW-1:LW]),
         .rd_data (bank_rd_data[b])
      );
   end

   assign up_ready = up_ready_w;
   assign dn_ena   = rd_start;
   assign dn_data  = rd_act ? bank_rd_data[rd_bank_q] : '0;
   assign blk_done = rd_last;
   assign ovf_err  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dct_transpose_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dct_transpose_ctrl : directed self-checking bench for the transpose   |
// | controller.                                  Revision: 1.0               |
// +--------------------------------------------------------------------------+
module tb_dct_transpose_ctrl;

   logic        clk;
   logic        rst;
   logic        up_valid;
   logic [11:0] up_data;
   logic        up_ready;
   logic        dn_rdy;
   logic        dn_hold;
   logic        dn_ena;
   logic [11:0] dn_data;
   logic        blk_done;
   logic        ovf_err;

   int checks = 0;
   int errors = 0;

   dct_transpose_ctrl #(.W(12), .N(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_data  (up_data),
      .up_ready (up_ready),
      .dn_rdy   (dn_rdy),
      .dn_hold  (dn_hold),
      .dn_ena   (dn_ena),
      .dn_data  (dn_data),
      .blk_done (blk_done),
      .ovf_err  (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: inputs change at the falling edge, outputs are sampled 1 ns later.
   task automatic cyc(input logic r, input logic v, input logic [11:0] d,
                      input logic rdy, input logic h);
      @(negedge clk);
      rst      = r;
      up_valid = v;
      up_data  = d;
      dn_rdy   = rdy;
      dn_hold  = h;
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Word j of a replayed block whose row-major contents were base+0..base+63.
   function automatic logic [11:0] tw(input int base, input int j);
      return 12'(base + (j % 8) * 8 + j / 8);
   endfunction

   task automatic chk_word(input int base, input int j);
      chkw("dn_data", dn_data, tw(base, j));
      chk1("dn_ena", dn_ena, (j % 8) == 0);
      chk1("blk_done", blk_done, j == 63);
   endtask

   task automatic chk_reset_outputs();
      chk1("rst_up_ready", up_ready, 1'b0);
      chk1("rst_dn_ena", dn_ena, 1'b0);
      chkw("rst_dn_data", dn_data, 12'd0);
      chk1("rst_blk_done", blk_done, 1'b0);
      chk1("rst_ovf_err", ovf_err, 1'b0);
   endtask

   initial begin
      rst = 1'b1; up_valid = 1'b0; up_data = '0; dn_rdy = 1'b0; dn_hold = 1'b0;

      // Reset, then up_ready appears one cycle after release
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk_reset_outputs();

      // Three ramp blocks back-to-back; the first also covers the single-block case
      for (int t = 0; t < 256; t++) begin
         cyc(0, t < 192, 12'(t < 192 ? t : 0), 1, 0);
         if (t < 192) chk1("t2_up_ready", up_ready, 1'b1);
         if (t >= 64) begin
            chk_word(((t - 64) / 64) * 64, (t - 64) % 64);
         end else begin
            chk1("t2_no_ena", dn_ena, 1'b0);
            chkw("t2_idle_data", dn_data, 12'd0);
         end
      end

      // Consumer blocked for two blocks: both banks fill, then drain in order
      for (int i = 0; i < 128; i++) begin
         cyc(0, 1, 12'(256 + i), 0, 0);
         chk1("t3_up_ready_fill", up_ready, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0);
         chk1("t3_up_ready_full", up_ready, 1'b0);
         chk1("t3_no_ena", dn_ena, 1'b0);
         chkw("t3_idle_data", dn_data, 12'd0);
      end
      for (int j = 0; j < 64; j++) begin
         cyc(0, 0, 0, 1, 0);
         chk_word(256, j);
         chk1("t3_up_ready_drain", up_ready, 1'b0);
      end
      for (int j = 0; j < 64; j++) begin
         cyc(0, 1, 12'(384 + j), 1, 0);
         chk1("t3_up_ready_freed", up_ready, 1'b1);
         chk_word(320, j);
      end
      for (int j = 0; j < 64; j++) begin
         cyc(0, 0, 0, 1, 0);
         chk_word(384, j);
      end

      // Hold at column 2 word 4; dn_rdy dropped mid-burst must be ignored
      for (int i = 0; i < 64; i++) cyc(0, 1, 12'(i), 1, 0);
      for (int j = 0; j < 64; j++) begin
         if (j == 20) begin
            for (int h = 0; h < 3; h++) begin
               cyc(0, 0, 0, 1, 1);
               chkw("t4_hold_data", dn_data, 12'd34);
               chk1("t4_hold_ena", dn_ena, 1'b0);
               chk1("t4_hold_done", blk_done, 1'b0);
            end
         end
         cyc(0, 0, 0, (j % 8) == 0, 0);
         chk_word(0, j);
      end

      // Reset at wr_cnt=20, then a fresh block, reset mid-burst, fresh block again
      for (int i = 0; i < 20; i++) cyc(0, 1, 12'(2000 + i), 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      chk_reset_outputs();
      cyc(0, 0, 0, 1, 0);
      chk1("t5_up_ready_back", up_ready, 1'b1);
      chk1("t5_no_ena", dn_ena, 1'b0);
      for (int i = 0; i < 64; i++) begin
         cyc(0, 1, 12'(100 + i), 1, 0);
         chk1("t5_no_early_ena", dn_ena, 1'b0);
      end
      for (int j = 0; j < 11; j++) begin
         cyc(0, 0, 0, 1, 0);
         chk_word(100, j);
      end
      cyc(1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      chk_reset_outputs();
      cyc(0, 0, 0, 1, 0);
      chk1("t5_up_ready_back2", up_ready, 1'b1);
      chk1("t5_no_ena2", dn_ena, 1'b0);
      chkw("t5_no_data2", dn_data, 12'd0);
      for (int i = 0; i < 64; i++) cyc(0, 1, 12'(700 + i), 1, 0);
      for (int j = 0; j < 64; j++) begin
         cyc(0, 0, 0, 1, 0);
         chk_word(700, j);
      end

      // Overflow: write attempt into a full buffer is dropped and flagged sticky
      for (int i = 0; i < 128; i++) cyc(0, 1, 12'(1000 + i), 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk1("t6_up_ready", up_ready, 1'b0);
      chk1("t6_ovf_pre", ovf_err, 1'b0);
      cyc(0, 1, 12'hFFF, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0);
         chk1("t6_ovf_set", ovf_err, 1'b1);
      end
      for (int j = 0; j < 64; j++) begin
         cyc(0, 0, 0, 1, 0);
         chk_word(1000, j);
      end
      for (int j = 0; j < 64; j++) begin
         cyc(0, 0, 0, 1, 0);
         chk_word(1064, j);
      end
      cyc(0, 0, 0, 1, 0);
      chk1("t6_ovf_sticky", ovf_err, 1'b1);
      chk1("t6_drained_no_ena", dn_ena, 1'b0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk1("t6_ovf_cleared", ovf_err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
